// File: rtl/melody_pkg.sv
// melody_pkg: shared types and constants for the melody recorder.
//   note_code_t : 4-bit note code, C4..C5 = 0..7, SP (silence) = 8
//   state_t     : recorder FSM states
//   DUR_ONE     : duration reported for the silence/default read value
//   note_freq / note_half_period : note pitch table and its half-period
//                 in clock cycles (constant-folded for a given clk_freq)
package melody_pkg;

  typedef enum logic [3:0] {
    NOTE_C4 = 4'd0,
    NOTE_D4 = 4'd1,
    NOTE_E4 = 4'd2,
    NOTE_F4 = 4'd3,
    NOTE_G4 = 4'd4,
    NOTE_A4 = 4'd5,
    NOTE_B4 = 4'd6,
    NOTE_C5 = 4'd7,
    NOTE_SP = 4'd8
  } note_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REST = 2'd1,
    ST_NOTE = 2'd2
  } state_t;

  localparam int DUR_ONE = 8;

  function automatic int note_freq(input note_code_t c);
    case (c)
      NOTE_C4: note_freq = 262;
      NOTE_D4: note_freq = 294;
      NOTE_E4: note_freq = 330;
      NOTE_F4: note_freq = 349;
      NOTE_G4: note_freq = 392;
      NOTE_A4: note_freq = 440;
      NOTE_B4: note_freq = 494;
      NOTE_C5: note_freq = 523;
      default: note_freq = 0;
    endcase
  endfunction

  // Silence (and any unused code) plays as half-period 1.
  function automatic logic [19:0] note_half_period(input int clk_freq, input note_code_t c);
    int f;
    f = note_freq(c);
    if (f == 0) note_half_period = 20'd1;
    else        note_half_period = 20'(clk_freq / (2 * f));
  endfunction

endpackage

// File: rtl/melody_recorder_tick.sv
// eighth_sec_tick: modulus-DIV counter producing a one-cycle tick every
// DIV cycles. clr_i restarts the count so the first tick of a new segment
// lands exactly DIV cycles after the clearing edge.
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : synchronous restart of the count
//   tick_o     : high during the last cycle of each DIV-cycle period
module eighth_sec_tick #(
  parameter int DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt_q <= '0;
    else if (clr_i)  cnt_q <= '0;
    else if (tick_o) cnt_q <= '0;
    else             cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/melody_recorder.sv
// melody_recorder: records notes played on eight keys as {code, duration}
// entries numbered 1..length, readable through a registered read port in
// the song-player encoding (half-period in cycles, duration in 1/8 s).
// Optional feature macro: RECORD_RESTS_EN (store gaps between notes as SP).
//   clk, reset          : clock, asynchronous active-high reset
//   rec_start_i/stop_i  : one-cycle record start / stop pulses (stop wins)
//   key_i               : debounced key levels, lowest set bit is the note
//   rd_addr_i           : entry number to read, data valid one cycle later
//   rd_period_o         : half-period of the entry (1 = silence)
//   rd_duration_o       : entry duration in 1/8 s units
//   length_o            : number of stored entries
//   recording_o, full_o : recorder busy / storage full flags
module melody_recorder
  import melody_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int DEPTH    = 63,
  parameter int ADDR_W   = 6,
  parameter int DUR_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_start_i,
  input  logic              rec_stop_i,
  input  logic [7:0]        key_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [19:0]       rd_period_o,
  output logic [DUR_W-1:0]  rd_duration_o,
  output logic [ADDR_W:0]   length_o,
  output logic              recording_o,
  output logic              full_o
);

  localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

  function automatic logic [2:0] lowest_key(input logic [7:0] k);
    lowest_key = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (k[i]) lowest_key = 3'(i);
    end
  endfunction

  state_t            state_q;
  note_code_t        cur_q;
  logic [DUR_W-1:0]  ticks_q;
  logic [ADDR_W:0]   length_q;
  logic              full_q;
  logic              recording_q;

  logic              tick;
  logic              seg_clr;
  logic              key_active;
  note_code_t        key_idx;
  logic [DUR_W-1:0]  dur_now;
  logic [DUR_W-1:0]  dur_note;
  logic              wr_en;
  note_code_t        wr_code;
  logic [DUR_W-1:0]  wr_dur;
  logic [ADDR_W-1:0] wr_addr;
  logic              full_hit;

  assign key_active = |key_i;
  assign key_idx    = note_code_t'({1'b0, lowest_key(key_i)});

  // The tick landing on the commit edge belongs to the closing segment.
  assign dur_now  = (ticks_q == DUR_MAX) ? DUR_MAX : ticks_q + DUR_W'(tick);
  assign dur_note = (dur_now == '0) ? DUR_W'(1) : dur_now;

  always_comb begin
    wr_en   = 1'b0;
    wr_code = cur_q;
    wr_dur  = dur_note;
    case (state_q)
      ST_NOTE: begin
        if (rec_stop_i || !key_active || key_idx != cur_q) wr_en = 1'b1;
      end
      ST_REST: begin
`ifdef RECORD_RESTS_EN
        // Only gaps between notes are kept; leading silence has length 0.
        if (!rec_stop_i && key_active && dur_now != '0 && length_q != '0) begin
          wr_en   = 1'b1;
          wr_code = NOTE_SP;
          wr_dur  = dur_now;
        end
`endif
      end
      default: ;
    endcase
  end

  assign wr_addr  = ADDR_W'(length_q + 1'b1);
  assign full_hit = wr_en && ((length_q + 1'b1) == DEPTH_L);
  assign seg_clr  = (state_q == ST_IDLE) || (state_q == ST_REST && key_active) || wr_en;

  eighth_sec_tick #(
    .DIV(CLK_FREQ / 8)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr_i (seg_clr),
    .tick_o(tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_q       <= NOTE_C4;
      ticks_q     <= '0;
      length_q    <= '0;
      full_q      <= 1'b0;
      recording_q <= 1'b0;
    end else begin
      if (seg_clr)                            ticks_q <= '0;
      else if (tick && ticks_q != DUR_MAX)    ticks_q <= ticks_q + 1'b1;
      if (wr_en) length_q <= length_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (rec_start_i && !rec_stop_i) begin
            length_q    <= '0;
            full_q      <= 1'b0;
            recording_q <= 1'b1;
            state_q     <= ST_REST;
          end
        end
        ST_REST: begin
          if (rec_stop_i) begin
            recording_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (key_active) begin
            if (full_hit) begin
              full_q      <= 1'b1;
              recording_q <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              cur_q   <= key_idx;
              state_q <= ST_NOTE;
            end
          end
        end
        ST_NOTE: begin
          if (wr_en) begin
            if (rec_stop_i || full_hit) begin
              full_q      <= full_hit;
              recording_q <= 1'b0;
              state_q     <= ST_IDLE;
            end else if (!key_active) begin
              state_q <= ST_REST;
            end else begin
              cur_q <= key_idx;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Entry storage: plain array with registered read, no reset on the data.
  logic [4+DUR_W-1:0] mem [0:(2**ADDR_W)-1];
  logic [4+DUR_W-1:0] rd_word_q;
  logic               rd_valid_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_code, wr_dur};
    rd_word_q <= mem[rd_addr_i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_valid_q <= 1'b0;
    else       rd_valid_q <= (rd_addr_i != '0) && ({1'b0, rd_addr_i} <= length_q);
  end

  assign rd_period_o   = rd_valid_q ? note_half_period(CLK_FREQ, note_code_t'(rd_word_q[DUR_W +: 4]))
                                    : 20'd1;
  assign rd_duration_o = rd_valid_q ? rd_word_q[DUR_W-1:0] : DUR_W'(DUR_ONE);
  assign length_o      = length_q;
  assign recording_o   = recording_q;
  assign full_o        = full_q;

endmodule
